// File: rtl/sdram_req_ctrl.sv
// sdram_req_ctrl: client-side sequencer for the SDRAM controller cpu/chipset port.
// Arbitrates refresh timer > video 8-word burst > host single word, drives the
// edge-triggered sd_cs handshake and returns read data to the granted port.
// Optional: define SDRAM_REQ_TIMEOUT_EN to add a per-transaction WAIT watchdog
// that aborts after TIMEOUT_CYCLES with an err pulse instead of an ack.
module sdram_req_ctrl #(
  parameter int REFRESH_CYCLES = 312,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [20:0] h_addr,
  input  logic [31:0] h_din,
  input  logic [3:0]  h_ds,
  output logic        h_ack,
  output logic [31:0] h_dout,
  input  logic        v_req,
  input  logic [20:0] v_addr,
  output logic        v_ack,
  output logic        v_wr,
  output logic [2:0]  v_idx,
  output logic [31:0] v_data,
  output logic        err,
  input  logic        sd_ready,
  input  logic        sd_cmd_ready,
  input  logic [31:0] sd_dout,
  input  logic        sd_dout_valid,
  output logic        sd_cs,
  output logic        sd_we,
  output logic        sd_refresh,
  output logic        sd_read_burst,
  output logic [20:0] sd_addr,
  output logic [31:0] sd_din,
  output logic [3:0]  sd_ds
);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  typedef enum logic [1:0] {OWN_HOST, OWN_VID, OWN_REF} own_t;

  state_t        state, state_nxt;
  own_t          own, gnt_own;
  logic          grant, done, tmo, tmo_hit;
  logic [RW-1:0] rcnt;
  logic          refresh_pend, wrap;
  logic [3:0]    word_cnt, exp_cnt;
  logic          first_wait;

  assign wrap = sd_ready && (rcnt == RW'(REFRESH_CYCLES - 1));

  // Refresh interval timer; a wrap during a pending refresh is simply absorbed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt         <= '0;
      refresh_pend <= 1'b0;
    end else begin
      if (sd_ready) rcnt <= wrap ? '0 : rcnt + 1'b1;
      // set wins so a wrap coinciding with a refresh grant is kept for next IDLE
      if (wrap)                            refresh_pend <= 1'b1;
      else if (grant && gnt_own == OWN_REF) refresh_pend <= 1'b0;
    end
  end

  // Next-state, arbitration and completion decode
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_own   = OWN_HOST;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (sd_ready && sd_cmd_ready && (refresh_pend || v_req || h_req)) begin
        grant     = 1'b1;
        state_nxt = ISSUE;
        if (refresh_pend) gnt_own = OWN_REF;
        else if (v_req)   gnt_own = OWN_VID;
        else              gnt_own = OWN_HOST;
      end
      ISSUE: state_nxt = WAIT;
      // controller may still show ready in the first WAIT cycle, so skip it
      WAIT: if (!first_wait && word_cnt == exp_cnt && sd_cmd_ready) begin
        done      = 1'b1;
        state_nxt = GAP;
      end else if (tmo_hit) begin
        tmo       = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; sd_cs registered from next state so reset drops it at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sd_cs      <= 1'b0;
      first_wait <= 1'b0;
      h_ack      <= 1'b0;
      v_ack      <= 1'b0;
    end else begin
      state      <= state_nxt;
      sd_cs      <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      first_wait <= (state == ISSUE);
      h_ack      <= done && own == OWN_HOST;
      v_ack      <= done && own == OWN_VID;
    end
  end

  // Command qualifiers latched on grant and held through the whole command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own           <= OWN_HOST;
      sd_addr       <= '0;
      sd_din        <= '0;
      sd_ds         <= '0;
      sd_we         <= 1'b0;
      sd_refresh    <= 1'b0;
      sd_read_burst <= 1'b0;
      exp_cnt       <= '0;
    end else if (grant) begin
      own <= gnt_own;
      case (gnt_own)
        OWN_REF: begin
          sd_addr <= '0;     sd_din <= '0;       sd_ds <= '0;
          sd_we <= 1'b0;     sd_refresh <= 1'b1; sd_read_burst <= 1'b0;
          exp_cnt <= 4'd0;
        end
        OWN_VID: begin
          sd_addr <= v_addr; sd_din <= '0;       sd_ds <= 4'hF;
          sd_we <= 1'b0;     sd_refresh <= 1'b0; sd_read_burst <= 1'b1;
          exp_cnt <= 4'd8;
        end
        default: begin
          sd_addr <= h_addr; sd_din <= h_din;    sd_ds <= h_ds;
          sd_we <= h_we;     sd_refresh <= 1'b0; sd_read_burst <= 1'b0;
          exp_cnt <= h_we ? 4'd0 : 4'd1;
        end
      endcase
    end
  end

  // Read data return; valid strobes outside WAIT are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      v_wr     <= 1'b0;
      v_idx    <= '0;
      v_data   <= '0;
      h_dout   <= '0;
    end else begin
      v_wr <= 1'b0;
      if (grant) word_cnt <= '0;
      if (state == WAIT && sd_dout_valid) begin
        word_cnt <= word_cnt + 1'b1;
        if (own == OWN_VID) begin
          v_wr   <= 1'b1;
          v_data <= sd_dout;
          v_idx  <= word_cnt[2:0];
        end else if (own == OWN_HOST && !sd_we) begin
          h_dout <= sd_dout;
        end
      end
    end
  end

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  assign tmo_hit = (wait_cnt == TW'(TIMEOUT_CYCLES));

  // WAIT cycle counter (1 in first WAIT cycle) and abort pulse shown in GAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= tmo;
      if (state == ISSUE)                         wait_cnt <= TW'(1);
      else if (state == WAIT && !tmo_hit)          wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_req_ctrl.sv
// Bench for sdram_req_ctrl: behavioural SDRAM controller model with its own
// memory, an independent reference memory updated from the requests issued,
// and a command log used to check ordering, qualifier stability and refresh rate.
module tb_sdram_req_ctrl;
  localparam int RC = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        h_req = 0, h_we = 0, h_ack;
  logic [20:0] h_addr = '0, v_addr = '0;
  logic [31:0] h_din = '0, h_dout;
  logic [3:0]  h_ds = '0;
  logic        v_req = 0, v_ack, v_wr, err;
  logic [2:0]  v_idx;
  logic [31:0] v_data;
  logic        sd_ready = 0, sd_cmd_ready = 1, sd_dout_valid = 0;
  logic [31:0] sd_dout = '0;
  logic        sd_cs, sd_we, sd_refresh, sd_read_burst;
  logic [20:0] sd_addr;
  logic [31:0] sd_din;
  logic [3:0]  sd_ds;

  always #5 clk = ~clk;

  sdram_req_ctrl #(.REFRESH_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_din(h_din), .h_ds(h_ds),
    .h_ack(h_ack), .h_dout(h_dout),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_wr(v_wr), .v_idx(v_idx),
    .v_data(v_data), .err(err),
    .sd_ready(sd_ready), .sd_cmd_ready(sd_cmd_ready), .sd_dout(sd_dout),
    .sd_dout_valid(sd_dout_valid), .sd_cs(sd_cs), .sd_we(sd_we),
    .sd_refresh(sd_refresh), .sd_read_burst(sd_read_burst), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_ds(sd_ds)
  );

  int n_tests = 0, n_fail = 0;

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] dram [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] dram_rd(input logic [20:0] a);
    return dram.exists(int'(a)) ? dram[int'(a)] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] ds);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (ds[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- controller model ----------------
  bit          busy = 0, hold = 0, hang = 0, spur = 0;
  int          lat, left, idx, n_ref = 0, stab_err = 0;
  logic        cs_prev = 0;
  logic [59:0] c_vec;
  logic [20:0] c_addr;
  logic [31:0] c_din;
  logic [3:0]  c_ds;
  bit          c_we;
  int          cmd_log[$];

  always @(negedge clk) begin
    sd_dout_valid = 0;
    if (!reset_n) begin
      busy = 0; cs_prev = 0;
    end else begin
      if (busy && !sd_cs && cs_prev) busy = 0;            // aborted by the requester side
      if (sd_cs && !cs_prev) begin
        busy = 1; lat = $urandom_range(1, 3); idx = 0;
        c_vec = {sd_addr, sd_we, sd_ds, sd_din, sd_refresh, sd_read_burst};
        c_addr = sd_addr; c_din = sd_din; c_ds = sd_ds; c_we = sd_we;
        left = sd_refresh ? 0 : sd_read_burst ? 8 : sd_we ? 0 : 1;
        cmd_log.push_back(sd_refresh ? 2 : sd_read_burst ? 1 : 0);
        if (sd_refresh) n_ref++;
      end else if (busy) begin
        if (sd_cs && {sd_addr, sd_we, sd_ds, sd_din, sd_refresh, sd_read_burst} !== c_vec) stab_err++;
        if (hang) ;
        else if (lat > 0) lat--;
        else if (left > 0) begin
          sd_dout = dram_rd(c_addr + 21'(idx)); sd_dout_valid = 1; idx++; left--;
        end else begin
          busy = 0;
          if (c_we) dram[int'(c_addr)] = merge(dram_rd(c_addr), c_din, c_ds);
        end
      end else if (spur) begin
        sd_dout = 32'hBAD0BAD0; sd_dout_valid = 1; spur = 0;
      end
      cs_prev = sd_cs;
    end
    sd_cmd_ready = !busy && !hold;
  end

  // ---------------- output monitors ----------------
  int          n_vack = 0, n_err = 0, n_vwr = 0;
  logic [2:0]  vq_idx[$];
  logic [31:0] vq_dat[$];

  always @(negedge clk) begin
    if (v_wr) begin vq_idx.push_back(v_idx); vq_dat.push_back(v_data); n_vwr++; end
    if (v_ack) n_vack++;
    if (err) n_err++;
  end

  function automatic int n_nonref();
    int n = 0;
    foreach (cmd_log[i]) if (cmd_log[i] != 2) n++;
    return n;
  endfunction

  // ---------------- requesters ----------------
  task automatic host_op(input bit we, input logic [20:0] a, input logic [31:0] d,
                         input logic [3:0] ds, input string tag);
    logic [31:0] exp;
    int t;
    exp = ref_rd(a);
    if (we) ref_mem[int'(a)] = merge(exp, d, ds);
    h_we = we; h_addr = a; h_din = d; h_ds = ds; h_req = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!h_ack && t < 300);
    tb_check({tag, "_ack"}, h_ack, 1);
    if (!we) tb_check({tag, "_rd"}, h_dout, exp);
    h_req = 0;
  endtask

  task automatic vid_op(input logic [20:0] a, input string tag);
    int t;
    vq_idx.delete(); vq_dat.delete();
    v_addr = a; v_req = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!v_ack && t < 300);
    tb_check({tag, "_ack"}, v_ack, 1);
    v_req = 0;
    tb_check({tag, "_cnt"}, vq_dat.size(), 8);
    for (int i = 0; i < 8 && i < vq_dat.size(); i++) begin
      tb_check({tag, "_idx"}, vq_idx[i], i);
      tb_check({tag, "_dat"}, vq_dat[i], ref_rd(a + 21'(i)));
    end
  endtask

  // ---------------- main sequence ----------------
  int          nr0, base, k, t;
  logic [20:0] ra;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 8; i++) begin dram[32'h100 + i] = 32'h100 + i; ref_mem[32'h100 + i] = 32'h100 + i; end
    dram[32'h1FFFF0] = 32'hCAFEF00D; ref_mem[32'h1FFFF0] = 32'hCAFEF00D;
    dram[32'h123] = 32'h11111111;    ref_mem[32'h123] = 32'h11111111;
    for (int i = 0; i < 80; i++) begin
      rd = $urandom; dram[32'h1000 + i] = rd; ref_mem[32'h1000 + i] = rd;
    end

    repeat (3) @(negedge clk);
    tb_check("rst_ctl", {sd_cs, sd_we, sd_refresh, sd_read_burst, h_ack, v_ack, v_wr, err}, 0);
    tb_check("rst_data", {h_dout, v_data, sd_addr}, 0);
    reset_n = 1;
    repeat (20) @(negedge clk);
    tb_check("no_cs_unready", cmd_log.size(), 0);

    sd_ready = 1;
    nr0 = n_nonref();
    host_op(1, 21'h00123, 32'hDEADBEEF, 4'b0011, "hwr");
    tb_check("hwr_edges", n_nonref() - nr0, 1);
    @(negedge clk);
    tb_check("hwr_gap_cs", sd_cs, 0);
    host_op(0, 21'h00123, 0, 4'hF, "hwr_back");

    nr0 = n_nonref();
    host_op(0, 21'h1FFFF0, 0, 4'hF, "hrd");
    tb_check("hrd_edges", n_nonref() - nr0, 1);

    vid_op(21'h000100, "vid");
    tb_check("stable", stab_err, 0);

    // stray data strobe while idle must not reach either port
    repeat (4) @(negedge clk);
    k = n_vwr; rd = h_dout; spur = 1;
    repeat (4) @(negedge clk);
    tb_check("spur_vwr", n_vwr - k, 0);
    tb_check("spur_hdout", h_dout, rd);

    // refresh pending plus simultaneous host and video
    hold = 1;
    repeat (2) @(negedge clk);
    base = cmd_log.size();
    repeat (40) @(negedge clk);
    fork
      host_op(0, 21'h1004, 0, 4'hF, "pri_h");
      vid_op(21'h1008, "pri_v");
      begin repeat (3) @(negedge clk); hold = 0; end
    join
    tb_check("pri_first_ref", (cmd_log.size() > base) ? cmd_log[base] : -1, 2);
    k = -1; t = -1;
    for (int i = base; i < cmd_log.size(); i++)
      if (cmd_log[i] != 2) begin if (k < 0) k = cmd_log[i]; else if (t < 0) t = cmd_log[i]; end
    tb_check("pri_vid_then_host", {k[7:0], t[7:0]}, {8'd1, 8'd0});

    // idle refresh rate
    repeat (20) @(negedge clk);
    #1 base = n_ref;
    repeat (160) @(negedge clk);
    #1 tb_check("refresh_rate", n_ref - base, 10);

    // randomized traffic against the reference memory
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 2);
      ra = 21'h1000 + 21'($urandom_range(0, 63));
      case (k)
        0:       host_op(1, ra, $urandom, 4'($urandom_range(1, 15)), "r_wr");
        1:       host_op(0, ra, 0, 4'hF, "r_rd");
        default: vid_op(ra & ~21'h7, "r_vid");
      endcase
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    tb_check("stable_rand", stab_err, 0);

    // asynchronous reset in the middle of a video burst
    vq_dat.delete();
    v_addr = 21'h000100; v_req = 1;
    t = 0;
    while (vq_dat.size() < 3 && t < 300) begin @(negedge clk); t++; end
    tb_check("mid_started", vq_dat.size() >= 3, 1);
    k = n_vack;
    #2 reset_n = 0;
    #1 tb_check("mid_rst_cs", sd_cs, 0);
    tb_check("mid_rst_data", {h_dout, v_data}, 0);
    v_req = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    repeat (4) @(negedge clk);
    tb_check("mid_no_vack", n_vack - k, 0);
    host_op(0, 21'h1FFFF0, 0, 4'hF, "post_rst_h");
    vid_op(21'h000100, "post_rst_v");
    tb_check("no_err", n_err, 0);

`ifdef SDRAM_REQ_TIMEOUT_EN
    // controller that never answers: abort shows err in GAP after WAIT cycle 63
    repeat (10) @(negedge clk);
    hang = 1;
    h_we = 0; h_addr = 21'h1010; h_req = 1;
    t = 0; base = -1;
    while (t < 400) begin
      @(negedge clk); t++;
      if (sd_cs && !sd_refresh && base < 0) base = t;
      if (err && base >= 0) break;
    end
    tb_check("tmo_err", err, 1);
    tb_check("tmo_at", t - base, 64);
    tb_check("tmo_no_ack", h_ack, 0);
    h_req = 0; hang = 0;
    repeat (5) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sdram_req_ctrl.md
Name: sdram_req_ctrl

Overview:
Client-side sequencer for the SDRAM controller's cpu/chipset port. It arbitrates between a periodic refresh timer, a GDP video burst port and a host single-word port. It drives the controller's edge-triggered cs/we/refresh/read_burst handshake and collects returned data.

Parameters:
REFRESH_CYCLES, 312, clk cycles between refresh requests (≈7.8 us at 40 MHz)
TIMEOUT_CYCLES, 63, watchdog limit per transaction (used only with the optional feature)

Ports:
clk  in  1  system clock, same clock as the SDRAM controller
reset_n  in  1  asynchronous active-low reset
h_req  in  1  host request, level; held until h_ack
h_we  in  1  host write (1) / read (0)
h_addr  in  21  host word address
h_din  in  32  host write data
h_ds  in  4  host byte strobes
h_ack  out  1  one-cycle completion pulse
h_dout  out  32  host read data, valid with h_ack on reads
v_req  in  1  video 8-word burst read request, level; v_addr[2:0] must be 0
v_addr  in  21  video burst base word address
v_ack  out  1  one-cycle pulse after the eighth word
v_wr  out  1  video word strobe
v_idx  out  3  word index 0..7 for v_wr
v_data  out  32  video word, valid with v_wr
err  out  1  one-cycle watchdog abort pulse; tied 0 without the optional feature
sd_ready  in  1  controller init done
sd_cmd_ready  in  1  controller idle and ready
sd_dout  in  32  controller read data
sd_dout_valid  in  1  controller read data strobe
sd_cs  out  1  request to controller; the controller starts on a rising edge
sd_we  out  1  write select
sd_refresh  out  1  refresh select
sd_read_burst  out  1  8-word burst select
sd_addr  out  21  word address to controller
sd_din  out  32  write data to controller
sd_ds  out  4  byte strobes to controller

Behaviour:
- Reset (async, reset_n=0):
  - All outputs are 0; h_dout and v_data are 0.
  - Refresh counter is cleared; refresh is not pending; FSM is in IDLE.
  - Mid-transaction reset drops sd_cs immediately. No ack is issued.
- Refresh timer:
  - Counts when sd_ready=1 and wraps at REFRESH_CYCLES-1.
  - A wrap sets refresh_pend. refresh_pend clears when a refresh is issued.
  - A second wrap while pending is absorbed; there is no queueing.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - Leaves IDLE only when sd_ready=1 and sd_cmd_ready=1.
  - Priority is refresh_pend > v_req > h_req.
  - On grant, the FSM registers sd_addr, sd_din, sd_ds, sd_we, sd_refresh and sd_read_burst, then goes to ISSUE.
  - Video grant: sd_we=0, sd_read_burst=1, sd_ds=4'hF.
  - Refresh grant: sd_refresh=1, sd_we=0.
- ISSUE: sd_cs=1 for this cycle. Go to WAIT.
- WAIT:
  - sd_cs stays 1. All sd_* qualifiers are held stable, because the controller samples addr/we/ds throughout the command.
  - Read data words are counted on sd_dout_valid. Expected count is 1 for a host read, 8 for a video read, 0 for writes and refresh.
  - Completion: expected count reached AND sd_cmd_ready=1, checked no earlier than the 2nd WAIT cycle.
  - On completion: sd_cs=0, pulse the granted port's ack, go to GAP.
- GAP:
  - sd_cs stays 0 for exactly one cycle, guaranteeing the next rising edge.
  - Returns to IDLE.
  - Minimum request-to-request spacing is therefore ISSUE+WAIT+GAP.
- Data return latency:
  - v_wr/v_data/v_idx are registered one cycle after each sd_dout_valid. v_idx increments 0..7.
  - h_dout is captured on sd_dout_valid during a host read; h_ack follows completion.
  - sd_dout_valid outside WAIT is ignored.
- Requester rules:
  - A requester dropping its req before ack is undefined.
  - The FSM never re-grants the same request: ack is sent in GAP, and the requester must deassert in the cycle after ack.
- sd_ready low: no grants. A transaction in progress completes normally.
- Simultaneous events:
  - A refresh wrap in the same cycle as a grant stays pending for the next IDLE.
  - h_req and v_req asserted together: video wins, host waits one full transaction.

Optional Feature:
SDRAM_REQ_TIMEOUT_EN.
- Defined: a WAIT-cycle counter runs per transaction. Reaching TIMEOUT_CYCLES forces sd_cs=0, pulses err for 1 cycle, sends no ack, and goes to GAP. The requester must re-request.
- Undefined: no counter; err is constant 0; WAIT can last indefinitely.

Test Plan:
- Reset release with sd_ready=0 for 20 cycles -> no sd_cs. Then sd_ready=1 and h_req write addr 0x00123 din 0xDEADBEEF ds 4'b0011 -> one sd_cs rising edge with sd_we=1 and those values held; h_ack one pulse; one cycle of sd_cs=0 follows.
- Host read addr 0x1FFFF0, model returns 0xCAFEF00D -> h_dout=0xCAFEF00D at h_ack; exactly one sd_cs rising edge.
- Video read v_addr 0x000100, model returns 0x100..0x107 -> v_wr 8 pulses, v_idx 0..7, v_data 0x100..0x107 in order, then v_ack; sd_read_burst=1 for the whole command.
- h_req and v_req in the same cycle with a refresh wrap pending -> issue order refresh, video, host; each separated by a GAP cycle.
- REFRESH_CYCLES=16 with no traffic over 160 cycles -> 10 refresh commands with sd_refresh=1.
- reset_n low during WAIT of a video burst -> sd_cs=0 asynchronously; no v_ack. After release, the next request proceeds normally. With SDRAM_REQ_TIMEOUT_EN and a model that never returns data -> err pulse at WAIT cycle 63.
